// File: rtl/alu_mul_ctrl.sv
// Shift-and-add 8x8 multiply sequencer that borrows a shared combinational ALU.
// While idle, the host drives the ALU directly; while multiplying, the controller owns it.
module alu_mul_ctrl #(
  parameter int A = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [7:0]   op_a,
  input  logic [7:0]   op_b,
  input  logic [A:0]   host_cmd,
  input  logic [7:0]   host_a,
  input  logic [7:0]   host_b,
  input  logic [7:0]   alu_rslt,
  output logic [A:0]   alu_cmd,
  output logic [7:0]   alu_inA,
  output logic [7:0]   alu_inB,
  output logic         busy,
  output logic         done,
  output logic [7:0]   product,
  output logic         parity
);

  localparam logic [A:0] CMD_ADD = (A+1)'(4'b0011);
  localparam logic [A:0] CMD_LSH = (A+1)'(4'b0100);
  localparam logic [A:0] CMD_RSH = (A+1)'(4'b0101);
  localparam logic [A:0] CMD_PAR = (A+1)'(4'b1000);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD  = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    PAR  = 3'd4,
    DONE = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] mcand_q, mcand_d;
  logic [7:0] mplier_q, mplier_d;
  logic [7:0] product_q, product_d;
  logic       parity_q, parity_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    parity_d  = parity_q;
    alu_cmd   = '0;
    alu_inA   = 8'd0;
    alu_inB   = 8'd0;

    unique case (state_q)
      IDLE: begin
        alu_cmd = host_cmd;
        alu_inA = host_a;
        alu_inB = host_b;
        if (start) begin
          acc_d    = 8'd0;
          mcand_d  = op_a;
          mplier_d = op_b;
          if (op_b == 8'd0)  state_d = PAR;
          else if (op_b[0])  state_d = ADD;
          else               state_d = SHL;
        end
      end
      ADD: begin
        alu_cmd = CMD_ADD;
        alu_inA = acc_q;
        alu_inB = mcand_q;
        acc_d   = alu_rslt;
        state_d = SHL;
      end
      SHL: begin
        alu_cmd = CMD_LSH;
        alu_inA = 8'd1;
        alu_inB = mcand_q;
        mcand_d = alu_rslt;
        state_d = SHR;
      end
      SHR: begin
        alu_cmd  = CMD_RSH;
        alu_inA  = 8'd1;
        alu_inB  = mplier_q;
        mplier_d = alu_rslt;
        // The shifted multiplier arrives this cycle, so branch on the ALU result, not mplier_q.
        if (alu_rslt == 8'd0)  state_d = PAR;
        else if (alu_rslt[0])  state_d = ADD;
        else                   state_d = SHL;
      end
      PAR: begin
        alu_cmd   = CMD_PAR;
        alu_inA   = 8'd0;
        alu_inB   = acc_q;
        parity_d  = alu_rslt[0];
        product_d = acc_q;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= 8'd0;
      mcand_q   <= 8'd0;
      mplier_q  <= 8'd0;
      product_q <= 8'd0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      parity_q  <= parity_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;
  assign parity  = parity_q;

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Directed bench for alu_mul_ctrl; a behavioural ALU closes the loop on alu_rslt.
`timescale 1ns/1ps
module tb_alu_mul_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] op_a, op_b;
  logic [3:0] host_cmd;
  logic [7:0] host_a, host_b;
  logic [7:0] alu_rslt;
  logic [3:0] alu_cmd;
  logic [7:0] alu_inA, alu_inB;
  logic       busy, done;
  logic [7:0] product;
  logic       parity;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_cmd_3x5 [10];

  alu_mul_ctrl #(.A(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .host_cmd (host_cmd),
    .host_a   (host_a),
    .host_b   (host_b),
    .alu_rslt (alu_rslt),
    .alu_cmd  (alu_cmd),
    .alu_inA  (alu_inA),
    .alu_inB  (alu_inB),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .parity   (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared combinational ALU
  always_comb begin
    case (alu_cmd)
      4'b0011: alu_rslt = alu_inA + alu_inB;
      4'b0100: alu_rslt = alu_inB << alu_inA;
      4'b0101: alu_rslt = alu_inB >> alu_inA;
      4'b1000: alu_rslt = {7'd0, ^alu_inB};
      default: alu_rslt = alu_inA ^ alu_inB;
    endcase
  end

  // Accepts a start and returns the cycle (1 = first cycle after accept) in which done is seen.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b, output int cyc);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", busy, done);
    end
    n_checks++;
    if (product !== 8'h00 || parity !== 1'b0) begin
      n_fail++; $display("FAIL reset_result: product=%h parity=%b, required 00 0", product, parity);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_host_passthrough();
    host_cmd = 4'b0001; host_a = 8'h0F; host_b = 8'hF0;
    #1;
    n_checks++;
    if (alu_cmd !== 4'b0001 || alu_inA !== 8'h0F || alu_inB !== 8'hF0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL host_fwd: cmd=%b inA=%h inB=%h busy=%b, required 0001 0f f0 0", alu_cmd, alu_inA, alu_inB, busy);
    end
    host_cmd = 4'b0110; host_a = 8'h5A; host_b = 8'h3C;
    #1;
    n_checks++;
    if (alu_cmd !== 4'b0110 || alu_inA !== 8'h5A || alu_inB !== 8'h3C) begin
      n_fail++;
      $display("FAIL host_fwd2: cmd=%b inA=%h inB=%h, required 0110 5a 3c", alu_cmd, alu_inA, alu_inB);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_3x5();
    int cyc;
    int done_cyc;
    host_cmd = 4'b1111; host_a = 8'hAA; host_b = 8'h55;
    op_a = 8'd3; op_b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (alu_cmd !== 4'b0011 || alu_inA !== 8'h00 || alu_inB !== 8'h03 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_add_drive: cmd=%b inA=%h inB=%h busy=%b, required 0011 00 03 1", alu_cmd, alu_inA, alu_inB, busy);
    end
    done_cyc = 0;
    for (cyc = 1; cyc <= 10; cyc++) begin
      n_checks++;
      if (alu_cmd !== exp_cmd_3x5[cyc-1]) begin
        n_fail++;
        $display("FAIL seq_3x5 cycle %0d: cmd=%b, required %b", cyc, alu_cmd, exp_cmd_3x5[cyc-1]);
      end
      if (done && done_cyc == 0) done_cyc = cyc;
      @(posedge clk); #1;
    end
    n_checks++;
    if (done_cyc !== 10) begin
      n_fail++; $display("FAIL latency_3x5: done in cycle %0d, required 10", done_cyc);
    end
    n_checks++;
    if (product !== 8'h0F || parity !== 1'b0) begin
      n_fail++; $display("FAIL result_3x5: product=%h parity=%b, required 0f 0", product, parity);
    end
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL after_done_3x5: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_zero_mul();
    int cyc;
    do_mul(8'h7B, 8'h00, cyc);
    n_checks++;
    if (cyc !== 2) begin
      n_fail++; $display("FAIL latency_zero: done in cycle %0d, required 2", cyc);
    end
    n_checks++;
    if (product !== 8'h00 || parity !== 1'b0) begin
      n_fail++; $display("FAIL result_zero: product=%h parity=%b, required 00 0", product, parity);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_max_mul();
    int cyc;
    do_mul(8'hFF, 8'hFF, cyc);
    n_checks++;
    if (cyc !== 26) begin
      n_fail++; $display("FAIL latency_ff: done in cycle %0d, required 26", cyc);
    end
    n_checks++;
    if (product !== 8'h01 || parity !== 1'b1) begin
      n_fail++; $display("FAIL result_ff: product=%h parity=%b, required 01 1", product, parity);
    end
    @(posedge clk); #1;
    n_checks++;
    if (product !== 8'h01 || parity !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL hold_ff: product=%h parity=%b done=%b, required 01 1 0", product, parity, done);
    end
  endtask

  task automatic test_ignore_start();
    int n_done;
    int done_cyc;
    op_a = 8'd3; op_b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    n_done = 0; done_cyc = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      start = (cyc == 3 || cyc == 9);
      op_a  = 8'hFF; op_b = 8'hFF;
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_checks++;
    if (n_done !== 1 || done_cyc !== 10) begin
      n_fail++; $display("FAIL busy_start: %0d done pulses, first in cycle %0d, required 1 in cycle 10", n_done, done_cyc);
    end
    n_checks++;
    if (product !== 8'h0F || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_result: product=%h busy=%b, required 0f 0", product, busy);
    end
  endtask

  task automatic test_start_in_done();
    op_a = 8'h7B; op_b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL done_cycle: done=%b, required 1", done);
    end
    op_b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL start_in_done: busy=%b, required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int cyc;
    bit saw_done;
    host_cmd = 4'b0000; host_a = 8'h00; host_b = 8'h00;
    op_a = 8'hFF; op_b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00 || parity !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b done=%b product=%h parity=%b, required 0 0 00 0", busy, done, product, parity);
    end
    n_checks++;
    if (alu_cmd !== 4'b0000 || alu_inA !== 8'h00 || alu_inB !== 8'h00) begin
      n_fail++; $display("FAIL abort_alu: cmd=%b inA=%h inB=%h, required 0000 00 00", alu_cmd, alu_inA, alu_inB);
    end
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done: saw_done=%b busy=%b, required 0 0", saw_done, busy);
    end
    do_mul(8'd2, 8'd3, cyc);
    n_checks++;
    if (cyc !== 8 || product !== 8'h06 || parity !== 1'b0) begin
      n_fail++; $display("FAIL post_abort_2x3: cycle %0d product=%h parity=%b, required 8 06 0", cyc, product, parity);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    exp_cmd_3x5[0] = 4'b0011; exp_cmd_3x5[1] = 4'b0100; exp_cmd_3x5[2] = 4'b0101;
    exp_cmd_3x5[3] = 4'b0100; exp_cmd_3x5[4] = 4'b0101; exp_cmd_3x5[5] = 4'b0011;
    exp_cmd_3x5[6] = 4'b0100; exp_cmd_3x5[7] = 4'b0101; exp_cmd_3x5[8] = 4'b1000;
    exp_cmd_3x5[9] = 4'b0000;
    start = 1'b0; op_a = 8'h00; op_b = 8'h00;
    host_cmd = 4'b0000; host_a = 8'h00; host_b = 8'h00;

    test_reset();
    test_host_passthrough();
    test_mul_3x5();
    test_zero_mul();
    test_max_mul();
    test_ignore_start();
    test_start_in_done();
    test_reset_abort();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
